imm_ext_stage: RTL and testbench

//  Parametrised, registered immediate-extension stage for the 16-bit RISC decode/register-read boundary.

---
 rtl/riscpro_pkg.sv | 18 +
 rtl/imm_ext_core.sv | 32 +++
 rtl/imm_ext_stage.sv | 100 ++++++++++
 tb/tb_imm_ext_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscpro_pkg.sv
// Shared decode-stage definitions: immediate extension modes and skid occupancy states.
package riscpro_pkg;

  localparam int unsigned IMM_MODE_W = 3;

  localparam logic [IMM_MODE_W-1:0] IMM_MODE_SE6  = 3'd0;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_SE9  = 3'd1;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_ZE8  = 3'd2;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_SE6S = 3'd3;
  localparam logic [IMM_MODE_W-1:0] IMM_MODE_LHI  = 3'd4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: raw field + mode -> DATA_W-bit immediate and illegal flag.
module imm_ext_core
  import riscpro_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 9
) (
  input  logic [IMM_W-1:0]      raw,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic [DATA_W-1:0]     imm,
  output logic                  illegal
);

  logic [DATA_W-1:0] se6;

  assign se6 = {{(DATA_W-6){raw[5]}}, raw[5:0]};

  // Select the extension rule; undefined modes yield zero and flag illegal
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (mode)
      IMM_MODE_SE6:  imm = se6;
      IMM_MODE_SE9:  imm = {{(DATA_W-9){raw[8]}}, raw[8:0]};
      IMM_MODE_ZE8:  imm = {{(DATA_W-8){1'b0}}, raw[7:0]};
      IMM_MODE_SE6S: imm = {se6[DATA_W-2:0], 1'b0};
      IMM_MODE_LHI:  imm = {raw[8:0], {(DATA_W-9){1'b0}}};
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer (head/tail) and valid/ready handshake.
module imm_ext_stage
  import riscpro_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 9,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_imm,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_illegal
);

  occ_state_t        state;
  logic [DATA_W-1:0] ext_imm;
  logic              ext_ill;
  logic [DATA_W-1:0] head_imm, tail_imm;
  logic [TAG_W-1:0]  head_tag, tail_tag;
  logic              head_ill, tail_ill;
  logic              push, pop;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .raw     (in_imm),
    .mode    (in_mode),
    .imm     (ext_imm),
    .illegal (ext_ill)
  );

  assign in_ready    = (state != OCC_TWO);
  assign out_valid   = (state != OCC_EMPTY);
  assign out_imm     = head_imm;
  assign out_tag     = head_tag;
  assign out_illegal = head_ill;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;

  // Occupancy FSM and head/tail storage; the head register always drives the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OCC_EMPTY;
      head_imm <= '0;
      head_tag <= '0;
      head_ill <= 1'b0;
      tail_imm <= '0;
      tail_tag <= '0;
      tail_ill <= 1'b0;
    end else if (flush) begin
      state <= OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            head_imm <= ext_imm;
            head_tag <= in_tag;
            head_ill <= ext_ill;
            state    <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && !pop) begin
            tail_imm <= ext_imm;
            tail_tag <= in_tag;
            tail_ill <= ext_ill;
            state    <= OCC_TWO;
          end else if (push && pop) begin
            // Head leaves and the new entry replaces it directly; occupancy unchanged
            head_imm <= ext_imm;
            head_tag <= in_tag;
            head_ill <= ext_ill;
          end else if (pop) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_imm <= tail_imm;
            head_tag <= tail_tag;
            head_ill <= tail_ill;
            state    <= OCC_ONE;
          end
        end
        default: state <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Scoreboard bench for imm_ext_stage: driver queues expected entries on accept, monitor pops on transfer.
module tb_imm_ext_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 9;
  localparam int unsigned TAG_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag;
    logic              ill;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm = '0;
  logic [2:0]        in_mode = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_imm;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal;

  int   checks = 0;
  int   fails  = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];

  imm_ext_stage #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm      (in_imm),
    .in_mode     (in_mode),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Reference model from the mode table using signed integer arithmetic
  function automatic exp_t model(input logic [IMM_W-1:0] raw, input logic [2:0] mode,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    int   v;
    int   r;
    r     = int'(raw);
    e.tag = tag;
    e.ill = 1'b0;
    e.imm = '0;
    case (int'(mode))
      0: begin v = r % 64;  if (v >= 32)  v -= 64;  e.imm = 16'(v); end
      1: begin v = r % 512; if (v >= 256) v -= 512; e.imm = 16'(v); end
      2: e.imm = 16'(r % 256);
      3: begin v = r % 64;  if (v >= 32)  v -= 64;  e.imm = 16'(v * 2); end
      4: e.imm = 16'((r % 512) * 128);
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one entry until accepted (bounded); queue its expected value at the accepting edge
  task automatic send(input logic [IMM_W-1:0] raw, input logic [2:0] mode,
                      input logic [TAG_W-1:0] tag, input exp_t exp, output int waited);
    bit done = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_imm   = raw;
    in_mode  = mode;
    in_tag   = tag;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: tag %0d not accepted after %0d cycles, expected acceptance", tag, waited);
    end
  endtask

  task automatic send_m(input logic [IMM_W-1:0] raw, input logic [2:0] mode, input logic [TAG_W-1:0] tag);
    int w;
    send(raw, mode, tag, model(raw, mode, tag), w);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted output transfer must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: got tag %0d imm 0x%0h, expected no output", out_tag, out_imm);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (out_imm !== e.imm || out_tag !== e.tag || out_illegal !== e.ill) begin
          fails++;
          $display("FAIL out_entry: got imm 0x%0h tag %0d ill %0b, expected imm 0x%0h tag %0d ill %0b",
                   out_imm, out_tag, out_illegal, e.imm, e.tag, e.ill);
        end
      end
    end
    if (flush) exp_q.delete();
  end

  // Optional random backpressure
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom);
  end

  exp_t e_dir;
  int   w;
  int   t0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_imm", 32'(out_imm), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_out_tag", 32'(out_tag), 32'd0);
    check("rel_out_illegal", 32'(out_illegal), 32'd0);

    // Directed extension vectors with literal expectations
    out_ready = 1'b1;
    e_dir = '{imm: 16'hFFE0, tag: 4'd1, ill: 1'b0}; send(9'h020, 3'd0, 4'd1, e_dir, w);
    e_dir = '{imm: 16'h001F, tag: 4'd2, ill: 1'b0}; send(9'h01F, 3'd0, 4'd2, e_dir, w);
    e_dir = '{imm: 16'hFFFF, tag: 4'd3, ill: 1'b0}; send(9'h1FF, 3'd1, 4'd3, e_dir, w);
    e_dir = '{imm: 16'h00FF, tag: 4'd4, ill: 1'b0}; send(9'h0FF, 3'd1, 4'd4, e_dir, w);
    e_dir = '{imm: 16'h00AB, tag: 4'd5, ill: 1'b0}; send(9'h1AB, 3'd2, 4'd5, e_dir, w);
    e_dir = '{imm: 16'hFFFE, tag: 4'd6, ill: 1'b0}; send(9'h03F, 3'd3, 4'd6, e_dir, w);
    e_dir = '{imm: 16'hD580, tag: 4'd7, ill: 1'b0}; send(9'h1AB, 3'd4, 4'd7, e_dir, w);
    e_dir = '{imm: 16'h0000, tag: 4'd8, ill: 1'b1}; send(9'h1FF, 3'd6, 4'd8, e_dir, w);
    e_dir = '{imm: 16'h0000, tag: 4'd9, ill: 1'b1}; send(9'h055, 3'd7, 4'd9, e_dir, w);
    e_dir = '{imm: 16'hFFC2, tag: 4'hA, ill: 1'b0}; send(9'h1E1, 3'd3, 4'hA, e_dir, w);
    drain();

    // Stall: two accepted, third held off
    out_ready = 1'b0;
    send_m(9'h011, 3'd0, 4'd1);
    send_m(9'h122, 3'd1, 4'd2);
    in_valid = 1'b1; in_imm = 9'h033; in_mode = 3'd2; in_tag = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_head_tag", 32'(out_tag), 32'd1);
    check("stall_head_imm", 32'(out_imm), 32'h0011);
    out_ready = 1'b1;
    send_m(9'h033, 3'd2, 4'd3);
    drain();

    // Simultaneous push/pop in ONE: one accept per cycle
    out_ready = 1'b1;
    send_m(9'h001, 3'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      logic [IMM_W-1:0] r;
      logic [2:0]       m;
      r = IMM_W'($urandom);
      m = 3'($urandom_range(0, 4));
      send(r, m, 4'(i + 1), model(r, m, 4'(i + 1)), w);
      check("tput_no_wait", 32'(w), 32'd0);
      check("tput_in_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Flush with TWO entries and a new input offered
    out_ready = 1'b0;
    send_m(9'h0AA, 3'd2, 4'd4);
    send_m(9'h0BB, 3'd2, 4'd5);
    in_valid = 1'b1; in_imm = 9'h0CC; in_mode = 3'd2; in_tag = 4'd6;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_leak", 32'(out_valid), 32'd0);

    // Async reset mid-stall with TWO entries
    out_ready = 1'b0;
    send_m(9'h1F0, 3'd1, 4'd7);
    send_m(9'h0F0, 3'd1, 4'd8);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_imm", 32'(out_imm), 32'd0);
    check("arst_out_tag", 32'(out_tag), 32'd0);
    check("arst_out_illegal", 32'(out_illegal), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_rel_in_ready", 32'(in_ready), 32'd1);
    check("arst_rel_out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_m(IMM_W'($urandom), 3'($urandom_range(0, 7)), 4'($urandom));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
